// File: rtl/nes_oam_dma_if.sv
// CPU-side and system-bus-side signals of the sprite DMA / bus master mux.
// master: the DMA block itself; slave: the CPU + bus environment around it.
interface nes_oam_dma_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
);
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_rw_n;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rdy;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_rw_n;
  logic [DATA_W-1:0] bus_rdata;
  logic              dma_busy;

  modport master (
    input  cpu_addr, cpu_wdata, cpu_rw_n, bus_rdata,
    output cpu_rdata, cpu_rdy, bus_addr, bus_wdata, bus_rw_n, dma_busy
  );

  modport slave (
    output cpu_addr, cpu_wdata, cpu_rw_n, bus_rdata,
    input  cpu_rdata, cpu_rdy, bus_addr, bus_wdata, bus_rw_n, dma_busy
  );
endinterface

// File: rtl/nes_oam_dma.sv
// Sprite OAM DMA engine: halts the CPU and copies one page to the PPU OAM data
// port with NES read/write cycle parity; transparent CPU<->bus mux when idle.
module nes_oam_dma #(
  parameter int unsigned       ADDR_W        = 16,
  parameter int unsigned       DATA_W        = 8,
  parameter logic [ADDR_W-1:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [ADDR_W-1:0] OAM_DATA_ADDR = 16'h2004,
  parameter int unsigned       XFER_LEN      = 256
) (
  input logic           clk,
  input logic           rst_n,
  nes_oam_dma_if.master io
);
  localparam int unsigned PAGE_W   = ADDR_W - 8;
  localparam int unsigned IDX_W    = 9;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(XFER_LEN - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic              cyc_odd;
  logic              busy_q;
  logic [PAGE_W-1:0] page, page_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [DATA_W-1:0] dbuf, dbuf_nxt;

  // State, parity and transfer registers; busy is registered from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cyc_odd <= 1'b0;
      busy_q  <= 1'b0;
      page    <= '0;
      idx     <= '0;
      dbuf    <= '0;
    end else begin
      state   <= state_nxt;
      cyc_odd <= ~cyc_odd;
      busy_q  <= (state_nxt != IDLE);
      page    <= page_nxt;
      idx     <= idx_nxt;
      dbuf    <= dbuf_nxt;
    end
  end

  // Next-state logic and bus mux; HALT/ALIGN turn any CPU access into a dummy read.
  always_comb begin
    state_nxt    = state;
    page_nxt     = page;
    idx_nxt      = idx;
    dbuf_nxt     = dbuf;
    io.bus_addr  = io.cpu_addr;
    io.bus_wdata = io.cpu_wdata;
    io.bus_rw_n  = io.cpu_rw_n;

    unique case (state)
      IDLE: begin
        if (!io.cpu_rw_n && (io.cpu_addr == DMA_REG_ADDR)) begin
          page_nxt  = PAGE_W'(io.cpu_wdata);
          idx_nxt   = '0;
          state_nxt = HALT;
        end
      end
      HALT: begin
        io.bus_rw_n = 1'b1;
        state_nxt   = cyc_odd ? READ : ALIGN;
      end
      ALIGN: begin
        io.bus_rw_n = 1'b1;
        state_nxt   = READ;
      end
      READ: begin
        io.bus_addr  = {page, idx[7:0]};
        io.bus_wdata = dbuf;
        io.bus_rw_n  = 1'b1;
        dbuf_nxt     = io.bus_rdata;
        state_nxt    = WRITE;
      end
      WRITE: begin
        io.bus_addr  = OAM_DATA_ADDR;
        io.bus_wdata = dbuf;
        io.bus_rw_n  = 1'b0;
        if (idx == LAST_IDX) begin
          state_nxt = IDLE;
        end else begin
          idx_nxt   = idx + IDX_W'(1);
          state_nxt = READ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign io.cpu_rdata = io.bus_rdata;
  assign io.cpu_rdy   = ~busy_q;
  assign io.dma_busy  = busy_q;

endmodule

// File: tb/tb_nes_oam_dma.sv
// Bench for nes_oam_dma: a 256-byte and a 4-byte instance share one CPU stimulus
// and one RAM image, and are checked every cycle against a cycle-count model.
module tb_nes_oam_dma;
  localparam int unsigned L0 = 256;
  localparam int unsigned L1 = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] cpu_addr = 16'h8000;
  logic [7:0]  cpu_wdata = 8'h00;
  logic        cpu_rw_n = 1'b1;
  logic [7:0]  mem [0:65535];
  logic [7:0]  oam0 [0:2047];
  logic [7:0]  oam1 [0:2047];
  int          wcnt0 = 0;
  int          wcnt1 = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  nes_oam_dma_if #(.ADDR_W(16), .DATA_W(8)) if0 ();
  nes_oam_dma_if #(.ADDR_W(16), .DATA_W(8)) if1 ();

  assign if0.cpu_addr  = cpu_addr;
  assign if0.cpu_wdata = cpu_wdata;
  assign if0.cpu_rw_n  = cpu_rw_n;
  assign if0.bus_rdata = mem[if0.bus_addr];
  assign if1.cpu_addr  = cpu_addr;
  assign if1.cpu_wdata = cpu_wdata;
  assign if1.cpu_rw_n  = cpu_rw_n;
  assign if1.bus_rdata = mem[if1.bus_addr];

  nes_oam_dma #(.XFER_LEN(L0)) dut0 (.clk(clk), .rst_n(rst_n), .io(if0));
  nes_oam_dma #(.XFER_LEN(L1)) dut1 (.clk(clk), .rst_n(rst_n), .io(if1));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  // Model: an active transfer is just a halted-cycle counter k; the bus activity
  // at cycle k follows from k, the start parity and the page.
  int         ncyc = 0;
  bit         m_act [2];
  int         m_k [2];
  int         m_total [2];
  int         m_align [2];
  logic [7:0] m_page [2];

  function automatic int len_of(input int d);
    return (d == 0) ? int'(L0) : int'(L1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ncyc <= 0;
      for (int d = 0; d < 2; d++) begin
        m_act[d] <= 1'b0;
        m_k[d]   <= 0;
      end
    end else begin
      ncyc <= ncyc + 1;
      for (int d = 0; d < 2; d++) begin
        if (m_act[d]) begin
          m_k[d] <= m_k[d] + 1;
          if (m_k[d] + 1 == m_total[d]) m_act[d] <= 1'b0;
        end else if (!cpu_rw_n && cpu_addr == 16'h4014) begin
          m_act[d]   <= 1'b1;
          m_k[d]     <= 0;
          m_page[d]  <= cpu_wdata;
          m_align[d] <= ncyc % 2;
          m_total[d] <= 1 + (ncyc % 2) + 2 * len_of(d);
        end
      end
    end
  end

  task automatic cmp_dut(input int d, input logic [15:0] a, input logic [7:0] wd,
                         input logic rw, input logic rdy, input logic busy,
                         input logic [7:0] rd);
    logic [15:0] ea;
    logic [7:0]  ewd;
    logic        erw;
    int          j;
    ea  = cpu_addr;
    ewd = cpu_wdata;
    erw = cpu_rw_n;
    if (m_act[d]) begin
      j = m_k[d] - 1 - m_align[d];
      if (j < 0) begin
        erw = 1'b1;
      end else if (j % 2 == 0) begin
        ea  = {m_page[d], 8'(j / 2)};
        erw = 1'b1;
      end else begin
        ea  = 16'h2004;
        erw = 1'b0;
        ewd = mem[{m_page[d], 8'(j / 2)}];
      end
    end
    chk($sformatf("d%0d_rdy", d), 32'(rdy), 32'(!m_act[d]));
    chk($sformatf("d%0d_busy", d), 32'(busy), 32'(m_act[d]));
    chk($sformatf("d%0d_addr", d), 32'(a), 32'(ea));
    chk($sformatf("d%0d_rw", d), 32'(rw), 32'(erw));
    if (!erw) chk($sformatf("d%0d_wdata", d), 32'(wd), 32'(ewd));
    chk($sformatf("d%0d_rdata", d), 32'(rd), 32'(mem[ea]));
  endtask

  always @(negedge clk) begin
    cmp_dut(0, if0.bus_addr, if0.bus_wdata, if0.bus_rw_n, if0.cpu_rdy, if0.dma_busy, if0.cpu_rdata);
    cmp_dut(1, if1.bus_addr, if1.bus_wdata, if1.bus_rw_n, if1.cpu_rdy, if1.dma_busy, if1.cpu_rdata);
  end

  // Capture every OAM data-port write, per instance.
  always @(posedge clk) begin
    if (!if0.bus_rw_n && if0.bus_addr == 16'h2004) begin
      oam0[wcnt0 % 2048] <= if0.bus_wdata;
      wcnt0 <= wcnt0 + 1;
    end
    if (!if1.bus_rw_n && if1.bus_addr == 16'h2004) begin
      oam1[wcnt1 % 2048] <= if1.bus_wdata;
      wcnt1 <= wcnt1 + 1;
    end
  end

  task automatic cpu_idle();
    cpu_addr  = 16'h8000;
    cpu_wdata = 8'h00;
    cpu_rw_n  = 1'b1;
  endtask

  // Trigger a DMA in a cycle of the given parity and run it to completion.
  task automatic trig(input logic [7:0] pg, input int par, input int exp0, input int exp1,
                      output int base0, output int base1);
    int cnt0, cnt1, guard, rd_par, bad;
    bit seen;
    guard = 0;
    @(posedge clk); #1;
    while ((ncyc % 2) != par && guard < 4) begin
      @(posedge clk); #1;
      guard++;
    end
    base0 = wcnt0;
    base1 = wcnt1;
    cpu_addr  = 16'h4014;
    cpu_wdata = pg;
    cpu_rw_n  = 1'b0;
    @(posedge clk); #1;
    cpu_idle();
    cnt0 = 0; cnt1 = 0; seen = 1'b0; rd_par = -1;
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      if (!if0.cpu_rdy) cnt0++;
      if (!if1.cpu_rdy) cnt1++;
      if (!seen && if0.dma_busy && if0.bus_rw_n && if0.bus_addr == {pg, 8'h00}) begin
        seen   = 1'b1;
        rd_par = ncyc % 2;
      end
      if (if0.cpu_rdy && if1.cpu_rdy) break;
    end
    chk("halt_cycles0", 32'(cnt0), 32'(exp0));
    chk("halt_cycles1", 32'(cnt1), 32'(exp1));
    chk("first_read_parity", 32'(rd_par), 32'd0);
    chk("oam_writes0", 32'(wcnt0 - base0), 32'(L0));
    chk("oam_writes1", 32'(wcnt1 - base1), 32'(L1));
    bad = 0;
    for (int i = 0; i < int'(L0); i++)
      if (oam0[(base0 + i) % 2048] !== mem[{pg, 8'(i)}]) bad++;
    chk("oam_data0", 32'(bad), 32'd0);
    bad = 0;
    for (int i = 0; i < int'(L1); i++)
      if (oam1[(base1 + i) % 2048] !== mem[{pg, 8'(i)}]) bad++;
    chk("oam_data1", 32'(bad), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, b1;
    for (int a = 0; a < 65536; a++) mem[a] = 8'(a) ^ 8'(a >> 8) ^ 8'h3C;

    #1 rst_n = 1'b0;
    #1;
    chk("rst_rdy0", 32'(if0.cpu_rdy), 32'd1);
    chk("rst_busy0", 32'(if0.dma_busy), 32'd0);
    chk("rst_rdy1", 32'(if1.cpu_rdy), 32'd1);
    chk("rst_busy1", 32'(if1.dma_busy), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Page 0x02, even trigger cycle, then odd trigger cycle.
    trig(8'h02, 0, 513, 9, b0, b1);
    chk("oam0_first", 32'(oam0[b0 % 2048]), 32'h3E);
    chk("oam0_last", 32'(oam0[(b0 + 255) % 2048]), 32'hC1);
    trig(8'h02, 1, 514, 10, b0, b1);

    // Idle pass-through read and write.
    @(posedge clk); #1;
    cpu_addr = 16'h0010; cpu_rw_n = 1'b1;
    @(negedge clk);
    chk("pt_rdata", 32'(if0.cpu_rdata), 32'h2C);
    chk("pt_rdy", 32'(if0.cpu_rdy), 32'd1);
    chk("pt_busy", 32'(if0.dma_busy), 32'd0);
    @(posedge clk); #1;
    cpu_addr = 16'h0300; cpu_wdata = 8'h5A; cpu_rw_n = 1'b0;
    @(negedge clk);
    chk("pt_waddr", 32'(if0.bus_addr), 32'h0300);
    chk("pt_wdata", 32'(if0.bus_wdata), 32'h5A);
    chk("pt_wrw", 32'(if0.bus_rw_n), 32'd0);
    chk("pt_wbusy", 32'(if0.dma_busy), 32'd0);
    @(posedge clk); #1;

    // Read of the trigger register and write to its neighbour: no DMA.
    cpu_addr = 16'h4014; cpu_wdata = 8'h02; cpu_rw_n = 1'b1;
    @(posedge clk); #1;
    cpu_addr = 16'h4015; cpu_rw_n = 1'b0;
    @(posedge clk); #1;
    cpu_idle();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("notrig_rdy0", 32'(if0.cpu_rdy), 32'd1);
      chk("notrig_rdy1", 32'(if1.cpu_rdy), 32'd1);
    end

    // Reset pulsed mid-transfer after the 100th OAM write.
    @(posedge clk); #1;
    b0 = wcnt0;
    cpu_addr = 16'h4014; cpu_wdata = 8'h02; cpu_rw_n = 1'b0;
    @(posedge clk); #1;
    cpu_idle();
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #2;
      if (wcnt0 - b0 >= 100) break;
    end
    chk("wr_before_rst", 32'(wcnt0 - b0), 32'd100);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_rdy", 32'(if0.cpu_rdy), 32'd1);
    chk("rst_mid_busy", 32'(if0.dma_busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("wr_after_rst", 32'(wcnt0 - b0), 32'd100);

    // Page 0xFF: the 4-byte instance reads FF00..FF03.
    trig(8'hFF, 0, 513, 9, b0, b1);
    chk("oam1_b0", 32'(oam1[b1 % 2048]), 32'hC3);
    chk("oam1_b1", 32'(oam1[(b1 + 1) % 2048]), 32'hC2);
    chk("oam1_b2", 32'(oam1[(b1 + 2) % 2048]), 32'hC1);
    chk("oam1_b3", 32'(oam1[(b1 + 3) % 2048]), 32'hC0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
